gbc_hdma_controller: RTL and testbench
======================================

Name: gbc_hdma_controller

Overview:
- CGB VRAM DMA engine (HDMA1-HDMA5, FF51-FF55) that sits upstream of the working memory bank.
- Masters the router to read source bytes (ROM/WRAM, including the banked WRAM window at D000-DFFF) and writes them into VRAM at 8000-9FFF.
- Supports general-purpose DMA (whole length at once, CPU halted) and H-blank DMA (16 bytes per H-blank, CPU halted only during each block).

Parameters:
- READ_LATENCY, 2, cycles from source address/RE_L assertion to valid I_SRC_DATA (router + BRAM); must be >= 1.

Ports:
- I_CLK  in  1  system clock
- I_RESET  in  1  synchronous reset, active-high
- I_IOREG_ADDR  in  16  IO register bus address
- IO_IOREG_DATA  inout  8  IO register bus data; driven only on a matching read, else high-Z
- I_IOREG_WE_L  in  1  IO register write strobe, active-low
- I_IOREG_RE_L  in  1  IO register read strobe, active-low
- I_IN_DMG_MODE  in  1  DMG mode; block disabled
- I_HBLANK  in  1  PPU mode-0 level
- O_SRC_ADDR  out  16  source read address to router
- O_SRC_RE_L  out  1  source read strobe, active-low
- I_SRC_DATA  in  8  source read data
- O_DST_ADDR  out  16  VRAM write address
- O_DST_DATA  out  8  VRAM write data
- O_DST_WE_L  out  1  VRAM write strobe, active-low
- O_CPU_HALT  out  1  stalls CPU while a block is moving
- O_ACTIVE  out  1  a transfer (GDMA or HDMA) is programmed and not finished

Behaviour:
- Reset:
  - O_SRC_RE_L=1, O_DST_WE_L=1, O_CPU_HALT=0, O_ACTIVE=0.
  - Addresses and data outputs = 0; FSM in IDLE.
  - Source = 0000, dest = 8000, remaining = 0x7F; IO data bus high-Z.
- Register writes (sampled on I_CLK while I_IOREG_WE_L=0):
  - FF51: src[15:8]. FF52: src[7:4]; bits 3:0 forced 0.
  - FF53: dst[12:8]; dst[15:13] forced 100. FF54: dst[7:4]; bits 3:0 forced 0.
  - FF51-54 writes are ignored while O_ACTIVE=1.
- FF55 write:
  - IDLE, bit7=0: GDMA of (d[6:0]+1)*16 bytes.
  - IDLE, bit7=1: HDMA of (d[6:0]+1) blocks.
  - Active HDMA, bit7=0: cancel after the current block (immediately if between blocks). Remaining keeps its value.
  - Active HDMA, bit7=1: ignored.
- Reads:
  - FF51-54 read 0xFF.
  - FF55 reads {~O_ACTIVE, remaining[6:0]}. remaining = blocks left - 1; reads 0xFF when a transfer completes normally.
- DMG mode: all writes ignored; FF55 reads 0xFF.
- FSM states: IDLE, GDMA, HWAIT (wait for I_HBLANK=1), HBLK (move one block), HEXIT (wait for I_HBLANK=0).
- Byte sub-cycle:
  - RD: O_SRC_ADDR=src, O_SRC_RE_L=0, held READ_LATENCY cycles.
  - WR: 1 cycle; O_DST_WE_L=0, O_DST_DATA = I_SRC_DATA captured at the end of RD.
  - Then src+=1, dst+=1. Cost: READ_LATENCY+1 cycles/byte, 48 cycles/block at default.
- Block end (every 16 bytes): remaining decrements, wrapping 00 -> 7F. The transfer ends when the decrement wraps.
- GDMA:
  - O_CPU_HALT=1 and O_ACTIVE=1 from the cycle after the FF55 write.
  - Both stay high until the cycle after the last WR, then IDLE.
- HDMA:
  - HWAIT -> HBLK when I_HBLANK=1 (including if already high at start).
  - HBLK holds O_CPU_HALT=1 for exactly one block, then goes to HEXIT.
  - HEXIT -> HWAIT on I_HBLANK=0, so at most one block per H-blank.
  - After the final block, or on cancel: IDLE, O_CPU_HALT=0.
- Wrap rules:
  - src wraps FFFF -> 0000.
  - dst wraps within 13 bits, 9FFF -> 8000; the transfer continues.
- I_RESET mid-transfer: everything returns to reset values on that edge. No further strobes; O_CPU_HALT low the following cycle.

Test Plan:
- Write FF51=C0, FF52=00, FF53=00, FF54=00, FF55=00 -> 16 writes to 8000-800F, 3 cycles apart, data = C000-C00F contents. Halt high for 48 cycles. FF55 then reads FF.
- FF52=1F, FF54=2A -> addresses start C010/8020 (low nibbles masked). Reads of FF51-FF54 return FF.
- HDMA FF55=82 with I_HBLANK pulsed 4 times -> exactly 3 blocks (48 bytes), one per H-blank, halt 48 cycles each. FF55 reads 01, 00, then FF between blocks.
- HDMA FF55=85, cancel with FF55=00 after 2 blocks -> no further writes, O_ACTIVE=0, FF55 reads 83.
- dst=9FF0, GDMA FF55=01 -> writes 9FF0-9FFF then 8000-800F.
- GDMA FF55=7F, I_RESET asserted at byte 100 -> strobes stop immediately, halt deasserts, FF55 reads FF. With I_IN_DMG_MODE=1 -> FF55 write starts nothing.

Source files
------------

// File: rtl/gbc_hdma_controller.sv
// CGB VRAM DMA engine (HDMA1-HDMA5, FF51-FF55).
// Copies 16-byte blocks from the router into VRAM, either all at once (GDMA) or one block per H-blank (HDMA).
module gbc_hdma_controller #(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_IOREG_ADDR,
  inout  wire  [7:0]  IO_IOREG_DATA,
  input  logic        I_IOREG_WE_L,
  input  logic        I_IOREG_RE_L,
  input  logic        I_IN_DMG_MODE,
  input  logic        I_HBLANK,
  output logic [15:0] O_SRC_ADDR,
  output logic        O_SRC_RE_L,
  input  logic [7:0]  I_SRC_DATA,
  output logic [15:0] O_DST_ADDR,
  output logic [7:0]  O_DST_DATA,
  output logic        O_DST_WE_L,
  output logic        O_CPU_HALT,
  output logic        O_ACTIVE
);

  localparam int unsigned RL_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [RL_W-1:0] RL_LAST = RL_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GDMA,
    ST_HWAIT,
    ST_HBLK,
    ST_HEXIT
  } state_t;

  state_t          state_q;
  logic [15:0]     src_q;
  logic [15:0]     dst_q;
  logic [6:0]      rem_q;
  logic            active_q;
  logic            halt_q;
  logic            cancel_q;
  logic            wr_phase_q;
  logic [RL_W-1:0] rd_cnt_q;
  logic [3:0]      byte_cnt_q;
  logic [15:0]     src_addr_q;
  logic            src_re_l_q;
  logic [15:0]     dst_addr_q;
  logic [7:0]      dst_data_q;
  logic            dst_we_l_q;

  logic [15:0]     src_d;
  logic [15:0]     dst_d;
  logic [6:0]      rem_d;
  logic [7:0]      io_wdata_c;
  logic            io_wr_c;
  logic            cfg_wr_c;
  logic            wr55_c;
  logic            cancel_c;
  logic            last_block_c;
  logic            rd_hit_c;
  logic [7:0]      rd_data_c;

  assign io_wdata_c   = IO_IOREG_DATA;
  assign io_wr_c      = !I_IOREG_WE_L && !I_IN_DMG_MODE;
  assign cfg_wr_c     = io_wr_c && !active_q;
  assign wr55_c       = io_wr_c && (I_IOREG_ADDR == 16'hFF55);
  assign cancel_c     = wr55_c && !io_wdata_c[7];
  assign last_block_c = (rem_q == 7'd0);

  // Post-byte address advance; destination stays inside the 8000-9FFF window.
  assign src_d = src_q + 16'd1;
  assign dst_d = {3'b100, dst_q[12:0] + 13'd1};
  assign rem_d = rem_q - 7'd1;

  assign O_SRC_ADDR = src_addr_q;
  assign O_SRC_RE_L = src_re_l_q;
  assign O_DST_ADDR = dst_addr_q;
  assign O_DST_DATA = dst_data_q;
  assign O_DST_WE_L = dst_we_l_q;
  assign O_CPU_HALT = halt_q;
  assign O_ACTIVE   = active_q;

  always_comb begin
    rd_hit_c  = 1'b0;
    rd_data_c = 8'hFF;
    if (!I_IOREG_RE_L) begin
      case (I_IOREG_ADDR)
        16'hFF51, 16'hFF52, 16'hFF53, 16'hFF54: rd_hit_c = 1'b1;
        16'hFF55: begin
          rd_hit_c  = 1'b1;
          rd_data_c = I_IN_DMG_MODE ? 8'hFF : {~active_q, rem_q};
        end
        default: ;
      endcase
    end
  end

  assign IO_IOREG_DATA = rd_hit_c ? rd_data_c : 8'hzz;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q    <= ST_IDLE;
      src_q      <= 16'h0000;
      dst_q      <= 16'h8000;
      rem_q      <= 7'h7F;
      active_q   <= 1'b0;
      halt_q     <= 1'b0;
      cancel_q   <= 1'b0;
      wr_phase_q <= 1'b0;
      rd_cnt_q   <= '0;
      byte_cnt_q <= 4'd0;
      src_addr_q <= 16'h0000;
      src_re_l_q <= 1'b1;
      dst_addr_q <= 16'h0000;
      dst_data_q <= 8'h00;
      dst_we_l_q <= 1'b1;
    end else begin
      // Address setup registers are frozen while a transfer is programmed.
      if (cfg_wr_c) begin
        case (I_IOREG_ADDR)
          16'hFF51: src_q[15:8] <= io_wdata_c;
          16'hFF52: src_q[7:0]  <= {io_wdata_c[7:4], 4'h0};
          16'hFF53: dst_q[15:8] <= {3'b100, io_wdata_c[4:0]};
          16'hFF54: dst_q[7:0]  <= {io_wdata_c[7:4], 4'h0};
          default: ;
        endcase
      end

      case (state_q)
        ST_IDLE: begin
          if (wr55_c) begin
            rem_q      <= io_wdata_c[6:0];
            active_q   <= 1'b1;
            cancel_q   <= 1'b0;
            byte_cnt_q <= 4'd0;
            wr_phase_q <= 1'b0;
            if (io_wdata_c[7]) begin
              state_q <= ST_HWAIT;
            end else begin
              state_q    <= ST_GDMA;
              halt_q     <= 1'b1;
              src_addr_q <= src_q;
              src_re_l_q <= 1'b0;
              rd_cnt_q   <= '0;
            end
          end
        end

        ST_HWAIT: begin
          if (cancel_c) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
          end else if (I_HBLANK) begin
            state_q    <= ST_HBLK;
            halt_q     <= 1'b1;
            byte_cnt_q <= 4'd0;
            wr_phase_q <= 1'b0;
            src_addr_q <= src_q;
            src_re_l_q <= 1'b0;
            rd_cnt_q   <= '0;
          end
        end

        ST_HEXIT: begin
          if (cancel_c) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
          end else if (!I_HBLANK) begin
            state_q <= ST_HWAIT;
          end
        end

        ST_GDMA, ST_HBLK: begin
          // A cancel during a block is remembered and honoured at the block boundary.
          if ((state_q == ST_HBLK) && cancel_c) begin
            cancel_q <= 1'b1;
          end
          if (!wr_phase_q) begin
            if (rd_cnt_q == RL_LAST) begin
              dst_data_q <= I_SRC_DATA;
              dst_addr_q <= dst_q;
              dst_we_l_q <= 1'b0;
              src_re_l_q <= 1'b1;
              wr_phase_q <= 1'b1;
            end else begin
              rd_cnt_q <= rd_cnt_q + RL_W'(1);
            end
          end else begin
            dst_we_l_q <= 1'b1;
            wr_phase_q <= 1'b0;
            src_q      <= src_d;
            dst_q      <= dst_d;
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'hF) begin
              rem_q <= rem_d;
              if (last_block_c || ((state_q == ST_HBLK) && (cancel_q || cancel_c))) begin
                state_q  <= ST_IDLE;
                halt_q   <= 1'b0;
                active_q <= 1'b0;
              end else if (state_q == ST_GDMA) begin
                src_addr_q <= src_d;
                src_re_l_q <= 1'b0;
                rd_cnt_q   <= '0;
              end else begin
                state_q <= ST_HEXIT;
                halt_q  <= 1'b0;
              end
            end else begin
              src_addr_q <= src_d;
              src_re_l_q <= 1'b0;
              rd_cnt_q   <= '0;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gbc_hdma_controller.sv
// Self-checking bench for gbc_hdma_controller: register vector table, scoreboard of VRAM writes, HDMA/reset/DMG sequences.
module tb_gbc_hdma_controller;

  logic        I_CLK;
  logic        I_RESET;
  logic [15:0] I_IOREG_ADDR;
  wire  [7:0]  IO_IOREG_DATA;
  logic        I_IOREG_WE_L;
  logic        I_IOREG_RE_L;
  logic        I_IN_DMG_MODE;
  logic        I_HBLANK;
  logic [15:0] O_SRC_ADDR;
  logic        O_SRC_RE_L;
  logic [7:0]  I_SRC_DATA;
  logic [15:0] O_DST_ADDR;
  logic [7:0]  O_DST_DATA;
  logic        O_DST_WE_L;
  logic        O_CPU_HALT;
  logic        O_ACTIVE;

  logic        tb_drv_en;
  logic [7:0]  tb_drv;
  assign IO_IOREG_DATA = tb_drv_en ? tb_drv : 8'hzz;

  gbc_hdma_controller #(.READ_LATENCY(2)) dut (
    .I_CLK        (I_CLK),
    .I_RESET      (I_RESET),
    .I_IOREG_ADDR (I_IOREG_ADDR),
    .IO_IOREG_DATA(IO_IOREG_DATA),
    .I_IOREG_WE_L (I_IOREG_WE_L),
    .I_IOREG_RE_L (I_IOREG_RE_L),
    .I_IN_DMG_MODE(I_IN_DMG_MODE),
    .I_HBLANK     (I_HBLANK),
    .O_SRC_ADDR   (O_SRC_ADDR),
    .O_SRC_RE_L   (O_SRC_RE_L),
    .I_SRC_DATA   (I_SRC_DATA),
    .O_DST_ADDR   (O_DST_ADDR),
    .O_DST_DATA   (O_DST_DATA),
    .O_DST_WE_L   (O_DST_WE_L),
    .O_CPU_HALT   (O_CPU_HALT),
    .O_ACTIVE     (O_ACTIVE)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    int          op;    // 0 = write, 1 = read and compare, 2 = wait for GDMA end
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;

  exp_t        exp_q[$];
  int          wr_times[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          halt_cnt = 0;
  int          wr_count = 0;
  int          exp_halt = 0;
  logic [15:0] m_src;
  logic [15:0] m_dst;

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;
  always @(posedge I_CLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Source memory pattern; data appears one registered stage after the read strobe.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return (a[7:0] + 8'h3C) ^ {a[11:8], a[15:12]};
  endfunction

  always @(posedge I_CLK) I_SRC_DATA <= O_SRC_RE_L ? 8'h00 : mem_byte(O_SRC_ADDR);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every VRAM strobe must match the oldest expected write.
  always @(negedge I_CLK) begin
    if (O_CPU_HALT === 1'b1) halt_cnt++;
    if (O_DST_WE_L === 1'b0) begin
      wr_count++;
      wr_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dst_write: got addr 0x%0h data 0x%0h, expected no write", O_DST_ADDR, O_DST_DATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dst_write", {8'h00, O_DST_ADDR, O_DST_DATA}, {8'h00, e.addr, e.data});
      end
    end
  end

  task automatic push_bytes(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = m_dst;
      e.data = mem_byte(m_src);
      exp_q.push_back(e);
      m_src = m_src + 16'd1;
      m_dst = {3'b100, m_dst[12:0] + 13'd1};
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge I_CLK);
    I_IOREG_ADDR = a;
    tb_drv       = d;
    tb_drv_en    = 1'b1;
    I_IOREG_WE_L = 1'b0;
    @(negedge I_CLK);
    I_IOREG_WE_L = 1'b1;
    tb_drv_en    = 1'b0;
  endtask

  task automatic io_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge I_CLK);
    I_IOREG_ADDR = a;
    I_IOREG_RE_L = 1'b0;
    #1;
    d = IO_IOREG_DATA;
    #1;
    I_IOREG_RE_L = 1'b1;
  endtask

  // CPU write with register model; a GDMA start queues every byte it should move.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    logic [15:0] src0;
    int          blocks;
    src0   = m_src;
    blocks = 0;
    case (a)
      16'hFF51: m_src[15:8] = d;
      16'hFF52: m_src[7:0]  = {d[7:4], 4'h0};
      16'hFF53: m_dst[15:8] = {3'b100, d[4:0]};
      16'hFF54: m_dst[7:0]  = {d[7:4], 4'h0};
      16'hFF55: if (!d[7]) begin
        blocks   = int'(d[6:0]) + 1;
        halt_cnt = 0;
        wr_count = 0;
        wr_times.delete();
        exp_halt = blocks * 48;
        push_bytes(blocks * 16);
      end
      default: ;
    endcase
    io_write(a, d);
    if (blocks != 0) begin
      check("gdma_start_halt_active", {30'd0, O_CPU_HALT, O_ACTIVE}, 32'd3);
      check("gdma_first_src", {16'd0, O_SRC_ADDR}, {16'd0, src0});
    end
  endtask

  task automatic wait_gdma(input int budget);
    int bad;
    for (int i = 0; i < budget && O_ACTIVE !== 1'b0; i++) @(negedge I_CLK);
    check("gdma_finished_in_budget", {31'd0, O_ACTIVE}, 32'd0);
    check("gdma_all_writes_seen", exp_q.size(), 0);
    check("gdma_halt_cycles", halt_cnt, exp_halt);
    bad = 0;
    for (int i = 1; i < wr_times.size(); i++) if (wr_times[i] - wr_times[i-1] != 3) bad++;
    check("gdma_byte_spacing", bad, 0);
  endtask

  task automatic hblank_pulse(input bit expect_block, input string tag);
    if (expect_block) push_bytes(16);
    @(negedge I_CLK);
    halt_cnt = 0;
    I_HBLANK = 1'b1;
    repeat (60) @(negedge I_CLK);
    I_HBLANK = 1'b0;
    repeat (20) @(negedge I_CLK);
    check({tag, "_halt_cycles"}, halt_cnt, expect_block ? 48 : 0);
    check({tag, "_writes_seen"}, exp_q.size(), 0);
  endtask

  vec_t        vecs[23];
  logic [7:0]  rd;
  logic [7:0]  hexp[4];

  initial begin
    vecs[0]  = '{1, 16'hFF55, 8'hFF};
    vecs[1]  = '{1, 16'hFF51, 8'hFF};
    vecs[2]  = '{0, 16'hFF51, 8'hC0};
    vecs[3]  = '{0, 16'hFF52, 8'h00};
    vecs[4]  = '{0, 16'hFF53, 8'h00};
    vecs[5]  = '{0, 16'hFF54, 8'h00};
    vecs[6]  = '{0, 16'hFF55, 8'h00};
    vecs[7]  = '{2, 16'h0000, 8'h00};
    vecs[8]  = '{1, 16'hFF55, 8'hFF};
    vecs[9]  = '{0, 16'hFF52, 8'h1F};
    vecs[10] = '{0, 16'hFF54, 8'h2A};
    vecs[11] = '{1, 16'hFF51, 8'hFF};
    vecs[12] = '{1, 16'hFF52, 8'hFF};
    vecs[13] = '{1, 16'hFF53, 8'hFF};
    vecs[14] = '{1, 16'hFF54, 8'hFF};
    vecs[15] = '{0, 16'hFF55, 8'h00};
    vecs[16] = '{2, 16'h0000, 8'h00};
    vecs[17] = '{1, 16'hFF55, 8'hFF};
    vecs[18] = '{0, 16'hFF53, 8'h1F};
    vecs[19] = '{0, 16'hFF54, 8'hF0};
    vecs[20] = '{0, 16'hFF55, 8'h01};
    vecs[21] = '{2, 16'h0000, 8'h00};
    vecs[22] = '{1, 16'hFF55, 8'hFF};
    hexp[0] = 8'h01;
    hexp[1] = 8'h00;
    hexp[2] = 8'hFF;
    hexp[3] = 8'hFF;

    I_RESET       = 1'b1;
    I_IOREG_ADDR  = 16'h0000;
    I_IOREG_WE_L  = 1'b1;
    I_IOREG_RE_L  = 1'b1;
    I_IN_DMG_MODE = 1'b0;
    I_HBLANK      = 1'b0;
    tb_drv_en     = 1'b0;
    tb_drv        = 8'h00;
    m_src         = 16'h0000;
    m_dst         = 16'h8000;

    repeat (3) @(negedge I_CLK);
    check("rst_strobes", {30'd0, O_SRC_RE_L, O_DST_WE_L}, 32'd3);
    check("rst_halt_active", {30'd0, O_CPU_HALT, O_ACTIVE}, 32'd0);
    check("rst_src_addr", {16'd0, O_SRC_ADDR}, 32'd0);
    check("rst_dst_addr_data", {8'd0, O_DST_ADDR, O_DST_DATA}, 32'd0);
    I_RESET = 1'b0;

    // Register vectors and three GDMA transfers (basic, masked start, VRAM wrap).
    for (int i = 0; i < 23; i++) begin
      case (vecs[i].op)
        0: cpu_write(vecs[i].addr, vecs[i].data);
        1: begin
          io_read(vecs[i].addr, rd);
          check($sformatf("vec%0d_read_%0h", i, vecs[i].addr), {24'd0, rd}, {24'd0, vecs[i].data});
        end
        default: wait_gdma(1200);
      endcase
    end

    // HDMA of 3 blocks, four H-blank pulses: one block per pulse, none on the fourth.
    cpu_write(16'hFF51, 8'hD0);
    cpu_write(16'hFF52, 8'h40);
    cpu_write(16'hFF53, 8'h01);
    cpu_write(16'hFF54, 8'h00);
    io_write(16'hFF55, 8'h82);
    check("hdma_start_halt_active", {30'd0, O_CPU_HALT, O_ACTIVE}, 32'd1);
    io_read(16'hFF55, rd);
    check("hdma_ff55_initial", {24'd0, rd}, 32'h02);
    for (int p = 0; p < 4; p++) begin
      hblank_pulse(p < 3, $sformatf("hdma_pulse%0d", p));
      io_read(16'hFF55, rd);
      check($sformatf("hdma_ff55_after%0d", p), {24'd0, rd}, {24'd0, hexp[p]});
    end

    // HDMA of 6 blocks cancelled between blocks after two have moved.
    io_write(16'hFF55, 8'h85);
    hblank_pulse(1'b1, "cancel_pulse0");
    hblank_pulse(1'b1, "cancel_pulse1");
    io_write(16'hFF55, 8'h00);
    check("cancel_active", {31'd0, O_ACTIVE}, 32'd0);
    io_read(16'hFF55, rd);
    check("cancel_ff55", {24'd0, rd}, 32'h83);
    hblank_pulse(1'b0, "cancel_after");

    // Long GDMA interrupted by reset after 100 bytes.
    cpu_write(16'hFF51, 8'h40);
    cpu_write(16'hFF52, 8'h00);
    cpu_write(16'hFF53, 8'h05);
    cpu_write(16'hFF54, 8'h00);
    cpu_write(16'hFF55, 8'h7F);
    for (int i = 0; i < 400 && wr_count < 100; i++) @(negedge I_CLK);
    check("reset_reached_byte100", {31'd0, wr_count >= 100}, 32'd1);
    I_RESET = 1'b1;
    @(negedge I_CLK);
    check("midreset_strobes", {30'd0, O_SRC_RE_L, O_DST_WE_L}, 32'd3);
    check("midreset_halt_active", {30'd0, O_CPU_HALT, O_ACTIVE}, 32'd0);
    @(negedge I_CLK);
    I_RESET = 1'b0;
    exp_q.delete();
    m_src = 16'h0000;
    m_dst = 16'h8000;
    repeat (20) @(negedge I_CLK);
    check("midreset_write_count", wr_count, 100);
    io_read(16'hFF55, rd);
    check("midreset_ff55", {24'd0, rd}, 32'hFF);

    // DMG mode: FF55 starts nothing and FF51 is not latched.
    I_IN_DMG_MODE = 1'b1;
    halt_cnt = 0;
    wr_count = 0;
    io_write(16'hFF51, 8'h12);
    io_write(16'hFF55, 8'h00);
    repeat (10) @(negedge I_CLK);
    check("dmg_no_transfer", {31'd0, O_ACTIVE}, 32'd0);
    check("dmg_no_halt_no_write", halt_cnt + wr_count, 0);
    io_read(16'hFF55, rd);
    check("dmg_ff55", {24'd0, rd}, 32'hFF);
    I_IN_DMG_MODE = 1'b0;
    cpu_write(16'hFF55, 8'h00);
    wait_gdma(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
